// File: rtl/bit_serial_pkg.sv
// bit_serial_pkg: types and constants shared by the serial link receiver
// and transmitter.
// Optional feature macro: BIT_SERIAL_RX_PARITY_EN. When it is defined, the
// receiver FSM gains a PARITY state for one even-parity bit per frame.
package bit_serial_pkg;

   localparam int   DEFAULT_WIDTH        = 8;
   localparam int   DEFAULT_CLKS_PER_BIT = 4;
   localparam logic IDLE_LEVEL           = 1'b1;

   // Receiver frame-walking states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef BIT_SERIAL_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_e;

   // Outcome of a frame, decided at the stop-bit sample and acted on one
   // cycle later by the output buffer.
   typedef enum logic [1:0] {
      EVT_NONE       = 2'd0,
      EVT_DELIVER    = 2'd1,
      EVT_FRAME_ERR  = 2'd2,
      EVT_PARITY_ERR = 2'd3
   } rx_evt_e;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/bit_serial_rx_sync.sv
// bit_sync: two-flop synchronizer for a single asynchronous input. Both
// flops reset to RESET_VAL, so a line that idles at that level does not
// appear to toggle when reset is released.
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: shift the input one stage per clock.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer flops.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of the others; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/bit_serial_rx.sv
// bit_serial_rx: receive end of the single-bit serial link. Synchronizes
// the line, walks the frame (start, WIDTH data bits LSB-first, optional
// even-parity bit, stop), and presents clean words on a one-entry
// valid/ready buffer. Framing, parity and overrun errors are one-cycle
// pulses.
// Optional feature macro: BIT_SERIAL_RX_PARITY_EN (adds the parity bit).
module bit_serial_rx
   import bit_serial_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH - 1);

   logic s_in;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   rx_evt_e          evt_q,   evt_d;
   logic             bit_tick;
   logic             par_pend;

   logic [WIDTH-1:0] out_data_q,   out_data_d;
   logic             out_valid_q,  out_valid_d;
   logic             frame_err_q,  frame_err_d;
   logic             overrun_q,    overrun_d;

   // Bring the asynchronous line into the clock domain.
   bit_sync #(
      .RESET_VAL (IDLE_LEVEL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in),
      .q     (s_in)
   );

`ifdef BIT_SERIAL_RX_PARITY_EN
   logic par_pend_q, par_pend_d;
   assign par_pend = par_pend_q;
`else
   assign par_pend = 1'b0;
`endif

   // Frame FSM: next state, bit timing and data shifting.
   // NOTE: every signal written here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      evt_d    = EVT_NONE;
`ifdef BIT_SERIAL_RX_PARITY_EN
      par_pend_d = par_pend_q;
`endif
      bit_tick = (cnt_q == '0);

      unique case (state_q)
         ST_IDLE: begin
            if (s_in != IDLE_LEVEL) begin
               state_d = ST_START;
               cnt_d   = HALF_RELOAD;
`ifdef BIT_SERIAL_RX_PARITY_EN
               par_pend_d = 1'b0;
`endif
            end
         end

         ST_START: begin
            if (!bit_tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (s_in != IDLE_LEVEL) begin
               state_d = ST_DATA;
               cnt_d   = FULL_RELOAD;
               idx_d   = '0;
            end else begin
               // Line went back high before mid start bit: a glitch.
               state_d = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (!bit_tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // LSB arrives first; after WIDTH shifts it sits in bit 0.
               shift_d = (shift_q >> 1) | (WIDTH'(s_in) << (WIDTH - 1));
               cnt_d   = FULL_RELOAD;
               if (idx_q == LAST_IDX) begin
`ifdef BIT_SERIAL_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

`ifdef BIT_SERIAL_RX_PARITY_EN
         ST_PARITY: begin
            if (!bit_tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (s_in != even_parity(32'(shift_q))) par_pend_d = 1'b1;
               cnt_d   = FULL_RELOAD;
               state_d = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (!bit_tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (s_in != IDLE_LEVEL) evt_d = EVT_FRAME_ERR;
               else if (par_pend)      evt_d = EVT_PARITY_ERR;
               else                    evt_d = EVT_DELIVER;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Frame FSM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         evt_q   <= EVT_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         evt_q   <= evt_d;
      end
   end

`ifdef BIT_SERIAL_RX_PARITY_EN
   // Pending parity mismatch for the frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_pend_q <= 1'b0;
      else        par_pend_q <= par_pend_d;
   end
`endif

   // Output buffer: accept a delivered word, or drop it when full.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !out_ready;
      overrun_d   = 1'b0;
      frame_err_d = (evt_q == EVT_FRAME_ERR);
      if (evt_q == EVT_DELIVER) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = shift_q;
            out_valid_d = 1'b1;
         end else begin
            // Consumer still holds the previous word: keep it, drop new one.
            out_valid_d = 1'b1;
            overrun_d   = 1'b1;
         end
      end
   end

   // Output buffer and status pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef BIT_SERIAL_RX_PARITY_EN
   logic parity_err_q, parity_err_d;

   // Parity error pulse, aligned with where out_valid would have risen.
   always_comb begin
      parity_err_d = (evt_q == EVT_PARITY_ERR);
   end

   // Parity error pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err_q <= 1'b0;
      else        parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_bit_serial_rx.sv
// tb_bit_serial_rx: directed bench for bit_serial_rx (WIDTH=8,
// CLKS_PER_BIT=4). Honours BIT_SERIAL_RX_PARITY_EN for frame format and
// the parity test steps.
module tb_bit_serial_rx;
   import bit_serial_pkg::*;

   localparam int W   = 8;
   localparam int CPB = 4;
`ifdef BIT_SERIAL_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int LAT = 2 + CPB / 2 + (W + 1 + P) * CPB + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         frame_err;
   logic         parity_err;
   logic         overrun;

   int total = 0;
   int bad   = 0;

   bit_serial_rx #(
      .WIDTH        (W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Edge counter and output monitor (sampled on the falling edge).
   int   cyc = 0;
   int   n_vrise = 0, n_vhigh = 0, vrise_cyc = 0;
   int   n_fe = 0, fe_cyc = 0;
   int   n_pe = 0, pe_cyc = 0;
   int   n_ov = 0, ov_cyc = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_valid <= out_valid;
      if (out_valid && !prev_valid) begin
         n_vrise   <= n_vrise + 1;
         vrise_cyc <= cyc;
      end
      if (out_valid) n_vhigh <= n_vhigh + 1;
      if (frame_err) begin
         n_fe   <= n_fe + 1;
         fe_cyc <= cyc;
      end
      if (parity_err) begin
         n_pe   <= n_pe + 1;
         pe_cyc <= cyc;
      end
      if (overrun) begin
         n_ov   <= n_ov + 1;
         ov_cyc <= cyc;
      end
   end

   int s_vrise, s_vhigh, s_fe, s_pe, s_ov;
   int t0, t0b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_vrise = n_vrise;
      s_vhigh = n_vhigh;
      s_fe    = n_fe;
      s_pe    = n_pe;
      s_ov    = n_ov;
   endtask

   // Wait n falling edges, then step past them so monitor updates settle.
   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input logic par_b);
      send_bit(1'b0);
      for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef BIT_SERIAL_RX_PARITY_EN
      send_bit(par_b);
`endif
      send_bit(stop_b);
      in = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in        = 1'b1;
      out_ready = 1'b1;

      // Reset state.
      settle(3);
      check("rst_out_data",   32'(out_data),   32'h0);
      check("rst_out_valid",  32'(out_valid),  32'h0);
      check("rst_frame_err",  32'(frame_err),  32'h0);
      check("rst_parity_err", 32'(parity_err), 32'h0);
      check("rst_overrun",    32'(overrun),    32'h0);
      rst_n = 1'b1;
      settle(3);

      // 0xA5, consumer ready: word after LAT cycles, valid for one cycle.
      snap();
      t0 = cyc + 1;
      send_frame(8'hA5, 1'b1, ^8'hA5);
      settle(6);
      check("a5_data",    32'(out_data), 32'hA5);
      check("a5_rise",    n_vrise - s_vrise, 1);
      check("a5_latency", vrise_cyc - t0, LAT);
      check("a5_vhigh",   n_vhigh - s_vhigh, 1);
      check("a5_fe",      n_fe - s_fe, 0);
      check("a5_pe",      n_pe - s_pe, 0);
      check("a5_ov",      n_ov - s_ov, 0);

      // 0x3C with a zero stop bit: one frame_err pulse, no word.
      snap();
      t0 = cyc + 1;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      settle(8);
      check("fe_count",   n_fe - s_fe, 1);
      check("fe_timing",  fe_cyc - t0, LAT);
      check("fe_rise",    n_vrise - s_vrise, 0);
      check("fe_valid",   32'(out_valid), 32'h0);
      check("fe_data",    32'(out_data), 32'hA5);

      // Half-bit low glitch: silently ignored.
      snap();
      in = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      in = 1'b1;
      settle(3 * CPB);
      check("gl_rise",  n_vrise - s_vrise, 0);
      check("gl_fe",    n_fe - s_fe, 0);
      check("gl_pe",    n_pe - s_pe, 0);
      check("gl_state", 32'(dut.state_q), 32'(ST_IDLE));

      // Back-to-back 0x11, 0x22 with consumer stalled: second word overruns.
      out_ready = 1'b0;
      snap();
      t0 = cyc + 1;
      send_frame(8'h11, 1'b1, ^8'h11);
      t0b = cyc + 1;
      send_frame(8'h22, 1'b1, ^8'h22);
      settle(6);
      check("b2b_first_lat", vrise_cyc - t0, LAT);
      check("b2b_data",      32'(out_data), 32'h11);
      check("b2b_valid",     32'(out_valid), 32'h1);
      check("b2b_ov",        n_ov - s_ov, 1);
      check("b2b_ov_timing", ov_cyc - t0b, LAT);
      check("b2b_fe",        n_fe - s_fe, 0);
      out_ready = 1'b1;
      settle(1);
      check("b2b_drain_valid", 32'(out_valid), 32'h0);
      check("b2b_drain_data",  32'(out_data), 32'h11);

`ifdef BIT_SERIAL_RX_PARITY_EN
      // 0x07 has three ones: even parity bit is 1.
      snap();
      t0 = cyc + 1;
      send_frame(8'h07, 1'b1, 1'b0);
      settle(6);
      check("par_bad_pe",     n_pe - s_pe, 1);
      check("par_bad_timing", pe_cyc - t0, LAT);
      check("par_bad_rise",   n_vrise - s_vrise, 0);
      snap();
      send_frame(8'h07, 1'b1, 1'b1);
      settle(6);
      check("par_ok_data", 32'(out_data), 32'h07);
      check("par_ok_rise", n_vrise - s_vrise, 1);
      check("par_ok_pe",   n_pe - s_pe, 0);
`endif

      // Hold a word, then reset in the middle of data bit 4.
      out_ready = 1'b0;
      send_frame(8'h5A, 1'b1, ^8'h5A);
      settle(6);
      check("pre_rst_valid", 32'(out_valid), 32'h1);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      in = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_data",  32'(out_data), 32'h0);
      check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      settle(2);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      settle(2);
      snap();
      send_frame(8'hFF, 1'b1, ^8'hFF);
      settle(6);
      check("post_rst_data", 32'(out_data), 32'hFF);
      check("post_rst_rise", n_vrise - s_vrise, 1);
      check("post_rst_fe",   n_fe - s_fe, 0);
      check("post_rst_ov",   n_ov - s_ov, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
